// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_e;

  localparam int DATA_BITS = 8;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk tick every DIV clocks, parked at zero by clr.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9_600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = cnt_width(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  if (DIV < 1) begin : g_bad_div
    $error("uart_baud_tick: CLK_FREQ/(BAUD*OVERSAMPLE) must be at least 1");
  end

  logic [DIV_W-1:0] div_cnt;

  // Divider counts 0..DIV-1 and restarts from zero whenever the line is idle,
  // so the first bit of a frame is exactly as long as every other bit.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (clr || div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick = !clr && (div_cnt == DIV_LAST);

endmodule

// File: rtl/uart_tx_engine.sv
// 8N1 UART transmitter draining a FIFO with combinational read data.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9_600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] fifo_rdata,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int TICK_W = cnt_width(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

  uart_tx_state_e       state, state_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [TICK_W-1:0]    tick_cnt, tick_cnt_nxt;
  logic [2:0]           bit_cnt, bit_cnt_nxt;
  logic                 tx_nxt, tx_done_nxt;
  logic                 baud_clr, tick, bit_end;

  assign baud_clr = (state == IDLE);

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (baud_clr),
    .tick (tick)
  );

  // Pop only from IDLE with data present; gating with reset keeps the FIFO
  // from losing a byte while the engine is held in reset.
  assign fifo_rd_en = (state == IDLE) && !fifo_empty && !reset;
  assign tx_busy    = (state != IDLE) || fifo_rd_en;
  assign bit_end    = tick && (tick_cnt == TICK_LAST);

  // Next-state, datapath and next-tx decode.
  // NOTE: every variable gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    tick_cnt_nxt = tick_cnt;
    bit_cnt_nxt  = bit_cnt;
    tx_done_nxt  = 1'b0;
    tx_nxt       = 1'b1;

    if (tick) begin
      tick_cnt_nxt = bit_end ? '0 : tick_cnt + TICK_W'(1);
    end

    unique case (state)
      IDLE: begin
        if (fifo_rd_en) begin
          shreg_nxt    = fifo_rdata;
          tick_cnt_nxt = '0;
          state_nxt    = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_cnt_nxt = '0;
          state_nxt   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_nxt = shreg >> 1;
          if (bit_cnt == BIT_LAST) begin
            state_nxt = STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          tx_done_nxt = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // tx is decoded from the state being entered so the line flop changes on
    // the same edge as the state register, with no logic after it.
    unique case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  // State, datapath and output registers; line idles high out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      tick_cnt <= tick_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      tx       <= tx_nxt;
      tx_done  <= tx_done_nxt;
    end
  end

endmodule
